snapshot_capture_buffer: RTL

- Downstream of the snapshot trigger stage.
- Stores the AXI-stream samples accepted while snapshot_enable is high into an on-chip buffer.
- After the trigger's snapshot_done pulse, replays the stored samples on a master AXI-stream with tlast on the final beat.
- Feeds the host readout path; the upstream ADC stream is never back-pressured.

---
 rtl/snapshot_pkg.sv | 13 +
 rtl/snapshot_buf_ram.sv | 31 +++
 rtl/snapshot_capture_buffer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/snapshot_pkg.sv
// snapshot_pkg: shared FSM state type and header field placement for the snapshot capture buffer
package snapshot_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  // The header overflow flag sits this many bits below DATA_W (1 -> the MSB).
  localparam int HDR_OVF_OFS = 1;

endpackage

// File: rtl/snapshot_buf_ram.sv
// snapshot_buf_ram: simple dual-port DEPTH x DATA_W RAM, one write port, registered 1-cycle read
module snapshot_buf_ram
  import snapshot_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_W-1:0]        o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Storage array is left unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read register only advances on i_re, so it holds the word across readout stalls.
  always_ff @(posedge clk) begin
    if (rst) o_rdata <= '0;
    else if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/snapshot_capture_buffer.sv
// snapshot_capture_buffer: captures samples during the snapshot window and replays them on AXI-stream; SNAP_HEADER_EN adds a count/overflow header beat
module snapshot_capture_buffer
  import snapshot_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int CNT_W  = 32
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              snapshot_enable,
  input  logic              snapshot_done,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic              overflow,
  output logic [CNT_W-1:0]  stored_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int HDR_BIT = DATA_W - HDR_OVF_OFS;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
`ifdef SNAP_HEADER_EN
  localparam logic HDR_EN = 1'b1;
`else
  localparam logic HDR_EN = 1'b0;
`endif

  state_t            r_state, w_state_nxt;
  logic [AW-1:0]     r_wr_ptr;
  logic [CNT_W-1:0]  r_rd_ptr, r_count, w_cnt_cap;
  logic              r_ovf, r_valid, r_last, r_busy, r_hdr_pend, r_hdr_out;
  logic [DATA_W-1:0] w_rdata, w_hdr;
  logic              w_beat, w_full, w_wr, w_hs, w_load, w_rd;

  assign s_axis_tready = !sys_rst;
  assign w_beat        = s_axis_tvalid && s_axis_tready;
  assign w_full        = r_count >= DEPTH_C;
  assign w_wr          = r_state == CAPTURE && w_beat && snapshot_enable && !w_full;
  assign w_cnt_cap     = r_count + CNT_W'(w_wr);
  assign w_hs          = r_valid && m_axis_tready;
  // Refill the single output slot when it is empty or being consumed; the header goes first.
  assign w_load        = r_state == DRAIN && (!r_valid || w_hs) && (r_hdr_pend || r_rd_ptr < r_count);
  assign w_rd          = w_load && !r_hdr_pend;

  assign m_axis_tdata  = r_hdr_out ? w_hdr : w_rdata;
  assign m_axis_tvalid = r_valid;
  assign m_axis_tlast  = r_last;
  assign busy          = r_busy;
  assign overflow      = r_ovf;
  assign stored_count  = r_count;

  // Header word: low bits of the count with the overflow flag overlaid on the top bit.
  always_comb begin
    w_hdr = r_count[DATA_W-1:0];
    w_hdr[HDR_BIT] = r_ovf;
  end

  // Next-state: an empty capture skips readout unless a header must still be sent.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = snapshot_enable ? CAPTURE : IDLE;
      CAPTURE: w_state_nxt = snapshot_done ? ((w_cnt_cap != '0 || HDR_EN) ? DRAIN : IDLE)
                                           : (snapshot_enable ? CAPTURE : IDLE);
      DRAIN:   w_state_nxt = (w_hs && r_last) ? IDLE : DRAIN;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end

  // Capture bookkeeping and readout slot control.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_busy     <= 1'b0;
      r_hdr_pend <= 1'b0;
      r_hdr_out  <= 1'b0;
    end else begin
      r_busy <= w_state_nxt != IDLE;
      if (r_state == IDLE && snapshot_enable) begin
        r_wr_ptr <= '0;
        r_count  <= '0;
        r_ovf    <= 1'b0;
      end
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        r_count  <= w_cnt_cap;
      end
      if (r_state == CAPTURE && w_beat && snapshot_enable && w_full) r_ovf <= 1'b1;
      if (r_state == CAPTURE && !snapshot_done && !snapshot_enable) r_count <= '0;
      r_hdr_pend <= (r_state == CAPTURE && w_state_nxt == DRAIN) ? HDR_EN : r_hdr_pend && !w_load;
      r_rd_ptr   <= r_state != DRAIN ? '0 : r_rd_ptr + CNT_W'(w_rd);
      if (w_load) begin
        r_valid   <= 1'b1;
        r_hdr_out <= r_hdr_pend;
        r_last    <= r_hdr_pend ? r_count == '0 : r_rd_ptr == r_count - CNT_W'(1);
      end else if (w_hs) begin
        r_valid   <= 1'b0;
        r_hdr_out <= 1'b0;
        r_last    <= 1'b0;
      end
    end
  end

  snapshot_buf_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .i_we    (w_wr),
    .i_waddr (r_wr_ptr),
    .i_wdata (s_axis_tdata),
    .i_re    (w_rd),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_rdata)
  );

endmodule
